// File: rtl/sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_controller_pkg
// Shared definitions for the external 16-bit asynchronous SRAM controller:
//   - sram_state_e        : 2-bit FSM encoding (IDLE/LOW/HIGH/DONE)
//   - SRAM_BASE_ADDR      : default CPU byte address mapped to SRAM word 0
//   - SRAM_ADDR_W         : default SRAM address width
//   - SRAM_WAIT           : default clocks per 16-bit phase
//   - SRAM_CNT_W          : phase counter width (covers WAIT_CYCLES up to 15)
//   - sram_word_offset()  : CPU byte address -> untruncated SRAM word index
// -----------------------------------------------------------------------------
package sram_controller_pkg;

    typedef enum logic [1:0] {
        SRAM_IDLE = 2'd0,
        SRAM_LOW  = 2'd1,
        SRAM_HIGH = 2'd2,
        SRAM_DONE = 2'd3
    } sram_state_e;

    localparam int SRAM_BASE_ADDR = 1024;
    localparam int SRAM_ADDR_W    = 18;
    localparam int SRAM_WAIT      = 2;
    localparam int SRAM_CNT_W     = 4;

    // Word index relative to the base; the caller truncates to its width.
    function automatic logic [31:0] sram_word_offset(input logic [31:0] addr,
                                                     input logic [31:0] base);
        logic [31:0] w_off;
        w_off = addr - base;
        return w_off >> 2;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// -----------------------------------------------------------------------------
// sram_wait_counter
// Phase timer shared by the low-half and high-half SRAM phases.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset (count -> 0)
//   i_clear  in   force count to 0 (has priority over i_en)
//   i_en     in   increment count
//   o_tc     out  terminal count: count == WAIT_CYCLES-1 (last cycle of phase)
// -----------------------------------------------------------------------------
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [SRAM_CNT_W-1:0] TC_VALUE = SRAM_CNT_W'(WAIT_CYCLES - 1);

    logic [SRAM_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Sequences MEM-stage LDR/STR requests onto a 16-bit asynchronous SRAM. Each
// 32-bit access is two phases (low half, then high half) of WAIT_CYCLES clocks;
// ready stays low until the access completes so the pipeline freezes.
//
// Optional feature macro: SRAM_RANGE_CHECK_EN
//   defined   : adds output mem_err; out-of-range addresses skip the SRAM and
//               complete in one cycle with mem_err=1 in the DONE cycle.
//   undefined : no mem_err port; out-of-range addresses wrap by truncation.
//
// Ports:
//   clk         in     system clock, rising edge
//   rst         in     asynchronous active-low reset
//   mem_read    in     LDR request, held until ready=1
//   mem_write   in     STR request, held until ready=1 (wins over mem_read)
//   address     in     CPU byte address (bits [1:0] ignored)
//   write_data  in     STR data
//   read_data   out    LDR result, valid in the cycle ready=1 ends a read
//   ready       out    0 = freeze pipeline
//   SRAM_DQ     inout  SRAM data bus (driven only during write phases)
//   SRAM_ADDR   out    SRAM half-word address {word, half}
//   SRAM_WE_N   out    SRAM write enable, active-low
//   mem_err     out    (SRAM_RANGE_CHECK_EN only) range error, one cycle
// -----------------------------------------------------------------------------
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int WAIT_CYCLES = SRAM_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_N
`ifdef SRAM_RANGE_CHECK_EN
    ,
    output logic              mem_err
`endif
);

    sram_state_e         r_state;
    sram_state_e         w_next;
    logic                r_is_write;
    logic [ADDR_W-2:0]   r_word;
    logic [31:0]         r_read_data;

    logic                w_req;
    logic                w_tc;
    logic                w_cnt_clear;
    logic                w_cnt_en;
    logic                w_phase;
    logic                w_dq_oe;
    logic                w_start;
    logic [ADDR_W-2:0]   w_word;
    logic [15:0]         w_dq_out;

    assign w_req  = mem_read | mem_write;
    assign w_word = (ADDR_W-1)'(sram_word_offset(address, 32'(BASE_ADDR)));

`ifdef SRAM_RANGE_CHECK_EN
    logic        w_range_err;
    logic        r_mem_err;
    logic [31:0] w_offset;

    // Word >= 2^(ADDR_W-1) is the same as the byte offset reaching 2^(ADDR_W+1).
    assign w_offset    = address - 32'(BASE_ADDR);
    assign w_range_err = (address < 32'(BASE_ADDR)) ||
                         ((w_offset >> (ADDR_W + 1)) != 32'd0);
    assign mem_err     = r_mem_err;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_tc    (w_tc)
    );

    // Next-state, ready and counter control
    always_comb begin
        w_next      = r_state;
        ready       = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            SRAM_IDLE: begin
                w_cnt_clear = 1'b1;
                if (w_req) begin
`ifdef SRAM_RANGE_CHECK_EN
                    if (w_range_err) begin
                        w_next = SRAM_DONE;
                    end else begin
                        w_next = SRAM_LOW;
                    end
`else
                    w_next = SRAM_LOW;
`endif
                end else begin
                    ready = 1'b1;
                end
            end
            SRAM_LOW: begin
                if (w_tc) begin
                    w_next      = SRAM_HIGH;
                    w_cnt_clear = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            SRAM_HIGH: begin
                if (w_tc) begin
                    w_next      = SRAM_DONE;
                    w_cnt_clear = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            SRAM_DONE: begin
                // Requests still held here are the one just served; never restart.
                ready       = 1'b1;
                w_cnt_clear = 1'b1;
                w_next      = SRAM_IDLE;
            end
            default: begin
                w_next = SRAM_IDLE;
            end
        endcase
    end

    assign w_start = (r_state == SRAM_IDLE) && (w_next == SRAM_LOW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SRAM_IDLE;
            r_is_write  <= 1'b0;
            r_word      <= '0;
            r_read_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_is_write <= mem_write;
                r_word     <= w_word;
            end
            // Capture each half on the edge that ends its phase.
            if (!r_is_write && w_tc) begin
                if (r_state == SRAM_LOW) begin
                    r_read_data[15:0] <= SRAM_DQ;
                end
                if (r_state == SRAM_HIGH) begin
                    r_read_data[31:16] <= SRAM_DQ;
                end
            end
        end
    end

`ifdef SRAM_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= (r_state == SRAM_IDLE) && (w_next == SRAM_DONE);
        end
    end
`endif

    assign w_phase  = (r_state == SRAM_LOW) || (r_state == SRAM_HIGH);
    assign w_dq_oe  = r_is_write && w_phase;
    assign w_dq_out = (r_state == SRAM_HIGH) ? write_data[31:16] : write_data[15:0];

    // WE_N rises on the last cycle of each phase so the address changes with WE_N high.
    assign SRAM_WE_N = ~(w_dq_oe && !w_tc);
    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'hzzzz;
    assign SRAM_ADDR = {r_word, (r_state == SRAM_HIGH)};
    assign read_data = r_read_data;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
`ifdef SRAM_RANGE_CHECK_EN
    logic        mem_err;
`endif

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N)
`ifdef SRAM_RANGE_CHECK_EN
        ,
        .mem_err    (mem_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple asynchronous SRAM model: 16 half-words, write sampled while WE_N low.
    logic [15:0] sram_mem [16];
    logic        tb_rd_drv;
    int          wr_cnt;
    int          dq_cnt;
    logic [17:0] wa_prev;
    logic [17:0] wa_last;

    assign SRAM_DQ = (tb_rd_drv && SRAM_WE_N) ? sram_mem[SRAM_ADDR[3:0]] : 16'hzzzz;

    initial begin
        wr_cnt  = 0;
        dq_cnt  = 0;
        wa_prev = '0;
        wa_last = '0;
        for (int i = 0; i < 16; i++) sram_mem[i] = 16'h0000;
    end

    always @(posedge clk) begin
        if (!SRAM_WE_N) begin
            sram_mem[SRAM_ADDR[3:0]] <= SRAM_DQ;
            wr_cnt  <= wr_cnt + 1;
            wa_prev <= wa_last;
            wa_last <= SRAM_ADDR;
        end
        if (dut.w_dq_oe) dq_cnt <= dq_cnt + 1;
    end

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One request, held until the ready=1 cycle, dropped after the edge ending it.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int low_cycles,
                           output logic [31:0] rdata, output logic err);
        logic got;
        got        = 1'b0;
        low_cycles = 0;
        rdata      = '0;
        err        = 1'b0;
        @(posedge clk);
        #1;
        tb_rd_drv  = rd && !wr;
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = wdata;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (ready) begin
                got   = 1'b1;
                rdata = read_data;
`ifdef SRAM_RANGE_CHECK_EN
                err   = mem_err;
`endif
            end else begin
                low_cycles++;
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tb_rd_drv = 1'b0;
        if (!got) begin
            $display("FAIL timeout: no ready within 50 cycles for addr %0h", addr);
            low_cycles = -1;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [17:0] exp_lo_addr;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          low;
        logic [31:0] rd_val;
        logic        err;
        int          wr0;
        int          dq0;
        logic [17:0] lo;

        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = '0;
        write_data = '0;
        tb_rd_drv  = 1'b0;

        //           rd    wr    addr   wdata          exp_rdata      lo     lo16     hi16
        vecs[0] = '{1'b0, 1'b1, 1028, 32'hDEADBEEF, 32'h00000000, 18'd2, 16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b1, 1'b0, 1028, 32'h00000000, 32'hDEADBEEF, 18'd2, 16'hBEEF, 16'hDEAD};
        vecs[2] = '{1'b1, 1'b1, 1024, 32'h12345678, 32'hDEADBEEF, 18'd0, 16'h5678, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 1040, 32'hA5A50F0F, 32'hDEADBEEF, 18'd8, 16'h0F0F, 16'hA5A5};
        vecs[4] = '{1'b1, 1'b0, 1040, 32'h00000000, 32'hA5A50F0F, 18'd8, 16'h0F0F, 16'hA5A5};
        vecs[5] = '{1'b1, 1'b0, 1024, 32'h00000000, 32'h12345678, 18'd0, 16'h5678, 16'h1234};
        vecs[6] = '{1'b0, 1'b1, 1031, 32'hCAFEF00D, 32'h12345678, 18'd2, 16'hF00D, 16'hCAFE};
        vecs[7] = '{1'b1, 1'b0, 1030, 32'h00000000, 32'hCAFEF00D, 18'd2, 16'hF00D, 16'hCAFE};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_rdata", read_data, 32'd0);
        check("rst_dq_z", 32'(dut.w_dq_oe), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            wr0 = wr_cnt;
            dq0 = dq_cnt;
            lo  = vecs[v].exp_lo_addr;
            run_txn(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, low, rd_val, err);
            check($sformatf("v%0d_ready_low", v), 32'(low), 32'd5);
            check($sformatf("v%0d_rdata", v), rd_val, vecs[v].exp_rdata);
            check($sformatf("v%0d_we_cycles", v), 32'(wr_cnt - wr0), vecs[v].wr ? 32'd2 : 32'd0);
            check($sformatf("v%0d_dq_cycles", v), 32'(dq_cnt - dq0), vecs[v].wr ? 32'd4 : 32'd0);
            check($sformatf("v%0d_mem_lo", v), 32'(sram_mem[lo[3:0]]), 32'(vecs[v].exp_lo));
            check($sformatf("v%0d_mem_hi", v), 32'(sram_mem[lo[3:0] + 4'd1]), 32'(vecs[v].exp_hi));
            if (vecs[v].wr) begin
                check($sformatf("v%0d_wr_addr_lo", v), 32'(wa_prev), 32'(lo));
                check($sformatf("v%0d_wr_addr_hi", v), 32'(wa_last), 32'(lo + 18'd1));
            end
            // Request was held through DONE: no second access may follow.
            wr0 = wr_cnt;
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_idle_ready", v), 32'(ready), 32'd1);
            check($sformatf("v%0d_no_restart", v), 32'(wr_cnt - wr0), 32'd0);
        end

        // WE_N within a write phase: low on first cycle, high on last
        @(posedge clk);
        #1;
        mem_write  = 1'b1;
        address    = 32'd1036;
        write_data = 32'h0BADF00D;
        @(posedge clk);
        #1;
        check("phase_we_first", 32'(SRAM_WE_N), 32'd0);
        check("phase_addr_lo", 32'(SRAM_ADDR), 32'd6);
        @(posedge clk);
        #1;
        check("phase_we_last", 32'(SRAM_WE_N), 32'd1);
        @(posedge clk);
        #1;
        check("phase_addr_hi", 32'(SRAM_ADDR), 32'd7);
        check("phase_dq_hi", 32'(SRAM_DQ), 32'h0BAD);

        // Reset while the high half is being written
        rst = 1'b0;
        #1;
        check("midrst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("midrst_dq_z", 32'(dut.w_dq_oe), 32'd0);
        check("midrst_addr", 32'(SRAM_ADDR), 32'd0);
        check("midrst_rdata", read_data, 32'd0);
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("postrst_ready", 32'(ready), 32'd1);
        check("postrst_we_n", 32'(SRAM_WE_N), 32'd1);

`ifdef SRAM_RANGE_CHECK_EN
        begin
            logic [31:0] rd_before;
            logic [17:0] addr_before;
            rd_before   = read_data;
            addr_before = SRAM_ADDR;
            wr0 = wr_cnt;
            dq0 = dq_cnt;
            run_txn(1'b1, 1'b0, 32'd512, 32'd0, low, rd_val, err);
            check("rng_ready_low", 32'(low), 32'd1);
            check("rng_mem_err", 32'(err), 32'd1);
            check("rng_rdata", rd_val, rd_before);
            check("rng_no_we", 32'(wr_cnt - wr0), 32'd0);
            check("rng_no_dq", 32'(dq_cnt - dq0), 32'd0);
            check("rng_addr", 32'(SRAM_ADDR), 32'(addr_before));
            check("rng_err_clear", 32'(mem_err), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
